coherence_control: RTL and testbench
====================================

Name: coherence_control

Overview:
- Bus-side responder for the two per-core icache/dcache pairs.
- Arbitrates all cache requests onto the single RAM port and services icache fetches and dcache reads/writes.
- For a coherent dcache miss, snoops the other core's dcache through ccwait/ccsnoopaddr. When that dcache holds the line, the word is forwarded cache-to-cache and written back to RAM in the same access.
- The dcache is the initiator of this protocol; this block is the other end.

Parameters:
- FIRST_PRIO, 0, core index that wins the first simultaneous-request arbitration after reset.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset
- iREN  in  2  icache read request, bit c = core c
- iaddr  in  2x32  icache word address per core
- iwait  out  2  icache stall; low for one cycle when iload is valid
- iload  out  2x32  fetched instruction
- dREN  in  2  dcache read request
- dWEN  in  2  dcache write request
- daddr  in  2x32  dcache word address
- dstore  in  2x32  dcache write data
- dwait  out  2  dcache stall; low for one cycle on completion
- dload  out  2x32  dcache read data
- cctrans  in  2  dcache coherent transaction / snoop hit
- ccwrite  in  2  dcache intends to write the line
- ccwait  out  2  snoop in progress for that dcache
- ccinv  out  2  snooped line must be invalidated
- ccsnoopaddr  out  2x32  address being snooped
- ramREN  out  1  RAM read
- ramWEN  out  1  RAM write
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=00, BUSY=01, ACCESS=10, ERROR=11

Behaviour:
- Reset (nRST async active-low, clock CLK):
  - state=IDLE; iwait=2'b11, dwait=2'b11.
  - ccwait, ccinv, ramREN, ramWEN = 0; ramaddr, ramstore, ccsnoopaddr = 0.
  - last_grant = ~FIRST_PRIO.
- Reset mid-transaction aborts the access with no RAM strobe on the following edge; requesters re-issue.
- Waits default high; only the granted requester's wait drops, for exactly the completion cycle.
- iload/dload are combinational from ramload, or from the forwarded dstore in FWD.
- Completion means ramstate==ACCESS. BUSY, FREE and ERROR all count as not done; ERROR is not a separate response.
- Arbitration, in IDLE, registered into gnt (1 bit) and kind:
  - Any dREN/dWEN beats any iREN.
  - Within a class, both cores requesting grants ~last_grant; last_grant updates on each grant.
  - A core requesting both i and d is served d first.
- Kind selection:
  - dWEN -> DWR.
  - dREN with cctrans -> SNOOP.
  - dREN without cctrans -> DRD.
  - iREN -> IRD.
- IRD:
  - ramREN=1, ramaddr=iaddr[gnt].
  - On ACCESS: iwait[gnt]=0, iload[gnt]=ramload, go IDLE.
- DRD: same as IRD on the d side.
- DWR:
  - ramWEN=1, ramaddr=daddr[gnt], ramstore=dstore[gnt].
  - On ACCESS: dwait[gnt]=0, go IDLE.
  - Write-back evictions use this path.
- SNOOP, one cycle, o = ~gnt:
  - ccwait[o]=1, ccsnoopaddr[o]=daddr[gnt], ccinv[o]=ccwrite[gnt].
  - Next edge: cctrans[o]=1 -> FWD; otherwise -> DRD, with ccwait dropped.
- FWD:
  - ccwait[o], ccsnoopaddr and ccinv stay held.
  - Wait for dWEN[o]; no RAM strobe until it arrives.
  - Then ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o], dload[gnt]=dstore[o].
  - On ACCESS: dwait[gnt]=0 and dwait[o]=0 in the same cycle, go IDLE, ccwait drops.
- New requests arriving during a transaction are held, not lost; they are re-arbitrated in IDLE.
- At most one RAM strobe is active per cycle. ramREN and ramWEN are never both high.
- A requester dropping its request mid-access does not abort the access. The access completes and its wait pulse is ignored.

Test Plan:
- Core0 iREN, iaddr=0x40, RAM answers ACCESS after 2 BUSY cycles with 0x8C220004 -> ramREN=1, ramaddr=0x40 for 3 cycles; iwait[0]=0 only in cycle 3; iload[0]=0x8C220004.
- Core0 iREN and core1 dWEN (0x100 <- 0xDEAD) asserted the same cycle -> DWR first (ramWEN, ramstore=0xDEAD); IRD for core0 follows; iwait[0] stays high throughout DWR.
- Both cores dREN (no cctrans), repeated 4 times after reset with FIRST_PRIO=0 -> grants in order 0,1,0,1.
- Core0 dREN+cctrans+ccwrite at 0x200, core1 cctrans=0 -> one SNOOP cycle with ccwait[1]=1, ccsnoopaddr[1]=0x200, ccinv[1]=1; then DRD from RAM; ccwait drops.
- Same, but core1 answers cctrans=1, then dWEN at 0x200 with 0xBEEF after 1 cycle -> ramWEN, ramaddr=0x200, ramstore=0xBEEF; dload[0]=0xBEEF; dwait[0] and dwait[1] both drop on ACCESS; no ramREN is issued.
- nRST pulsed low during FWD with ramWEN=1 -> ramWEN and ccwait go 0 immediately; all waits go high; state=IDLE; the pending request is re-served after reset deasserts.

Source files
------------

// File: rtl/coherence_control.sv
// Bus-side coherence responder for two icache/dcache core pairs: arbitrates the single
// RAM port, serves fetches and dcache reads/writes, and snoops the peer dcache on coherent misses.
module coherence_control #(
  parameter int FIRST_PRIO = 0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] iload,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate
);

  typedef enum logic [2:0] {IDLE, IRD, DRD, DWR, SNOOP, FWD} state_t;

  localparam logic P_FIRST = FIRST_PRIO[0];

  state_t r_state, w_nextState;
  logic   r_gnt, w_nextGnt;
  logic   r_lastGrant, w_nextLastGrant;
  logic   w_other, w_done, w_sel;
  logic [1:0] w_dReq;

  assign w_other = ~r_gnt;
  assign w_done  = (ramstate == 2'b10);
  assign w_dReq  = dREN | dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_gnt       <= 1'b0;
      r_lastGrant <= ~P_FIRST;
    end else begin
      r_state     <= w_nextState;
      r_gnt       <= w_nextGnt;
      r_lastGrant <= w_nextLastGrant;
    end
  end

  // Outputs are decoded from the registered state so an async reset kills strobes at once.
  always_comb begin
    w_nextState     = r_state;
    w_nextGnt       = r_gnt;
    w_nextLastGrant = r_lastGrant;
    w_sel           = 1'b0;
    iwait           = 2'b11;
    dwait           = 2'b11;
    iload[0]        = ramload;
    iload[1]        = ramload;
    dload[0]        = ramload;
    dload[1]        = ramload;
    ccwait          = 2'b00;
    ccinv           = 2'b00;
    ccsnoopaddr     = '0;
    ramREN          = 1'b0;
    ramWEN          = 1'b0;
    ramaddr         = 32'h0;
    ramstore        = 32'h0;

    case (r_state)
      IDLE: begin
        if (|w_dReq) begin
          w_sel           = (&w_dReq) ? ~r_lastGrant : w_dReq[1];
          w_nextGnt       = w_sel;
          w_nextLastGrant = w_sel;
          if (dWEN[w_sel])         w_nextState = DWR;
          else if (cctrans[w_sel]) w_nextState = SNOOP;
          else                     w_nextState = DRD;
        end else if (|iREN) begin
          w_sel           = (&iREN) ? ~r_lastGrant : iREN[1];
          w_nextGnt       = w_sel;
          w_nextLastGrant = w_sel;
          w_nextState     = IRD;
        end
      end
      IRD: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[r_gnt];
        if (w_done) begin
          iwait[r_gnt] = 1'b0;
          w_nextState  = IDLE;
        end
      end
      DRD: begin
        ramREN  = 1'b1;
        ramaddr = daddr[r_gnt];
        if (w_done) begin
          dwait[r_gnt] = 1'b0;
          w_nextState  = IDLE;
        end
      end
      DWR: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[r_gnt];
        ramstore = dstore[r_gnt];
        if (w_done) begin
          dwait[r_gnt] = 1'b0;
          w_nextState  = IDLE;
        end
      end
      SNOOP: begin
        ccwait[w_other]      = 1'b1;
        ccsnoopaddr[w_other] = daddr[r_gnt];
        ccinv[w_other]       = ccwrite[r_gnt];
        w_nextState          = cctrans[w_other] ? FWD : DRD;
      end
      FWD: begin
        // The peer's write-back doubles as the forwarded data for the requester.
        ccwait[w_other]      = 1'b1;
        ccsnoopaddr[w_other] = daddr[r_gnt];
        ccinv[w_other]       = ccwrite[r_gnt];
        dload[r_gnt]         = dstore[w_other];
        if (dWEN[w_other]) begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[w_other];
          ramstore = dstore[w_other];
          if (w_done) begin
            dwait       = 2'b00;
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_control.sv
// Directed testbench for coherence_control: each task drives one scenario and checks inline.
module tb_coherence_control;

  localparam logic [1:0] RS_FREE = 2'b00, RS_BUSY = 2'b01, RS_ACCESS = 2'b10;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic [1:0]       iREN = '0, dREN = '0, dWEN = '0, cctrans = '0, ccwrite = '0;
  logic [1:0][31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [1:0]       iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0] iload, dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore;
  logic [31:0]      ramload = '0;
  logic [1:0]       ramstate = RS_FREE;

  int nChecks = 0;
  int nFails  = 0;

  coherence_control #(.FIRST_PRIO(0)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearInputs();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;
  endtask

  task automatic test_reset();
    clearInputs();
    nRST = 1'b0;
    #1;
    nChecks++; if (iwait !== 2'b11) begin nFails++; $display("[TB] FAIL reset_iwait: got %b want 11", iwait); end
    nChecks++; if (dwait !== 2'b11) begin nFails++; $display("[TB] FAIL reset_dwait: got %b want 11", dwait); end
    nChecks++; if ({ccwait, ccinv, ramREN, ramWEN} !== 6'b0) begin nFails++; $display("[TB] FAIL reset_strobes: got %b want 0", {ccwait, ccinv, ramREN, ramWEN}); end
    nChecks++; if ({ramaddr, ramstore} !== 64'h0) begin nFails++; $display("[TB] FAIL reset_ram_bus: got %h want 0", {ramaddr, ramstore}); end
    nChecks++; if (ccsnoopaddr !== 64'h0) begin nFails++; $display("[TB] FAIL reset_snoopaddr: got %h want 0", ccsnoopaddr); end
    tick();
    nRST = 1'b1;
    tick();
    nChecks++; if ({ramREN, ramWEN, iwait, dwait} !== 6'b001111) begin nFails++; $display("[TB] FAIL idle_after_reset: got %b want 001111", {ramREN, ramWEN, iwait, dwait}); end
  endtask

  task automatic test_ifetch();
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = RS_BUSY;
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin ramstate = RS_ACCESS; ramload = 32'h8C220004; end
      #1;
      nChecks++; if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h40) begin nFails++; $display("[TB] FAIL ifetch_strobe_c%0d: got ren/wen %b addr %h want 10 / 40", c, {ramREN, ramWEN}, ramaddr); end
      nChecks++; if (iwait !== ((c == 3) ? 2'b10 : 2'b11)) begin nFails++; $display("[TB] FAIL ifetch_iwait_c%0d: got %b want %b", c, iwait, (c == 3) ? 2'b10 : 2'b11); end
      if (c < 3) tick();
    end
    nChecks++; if (iload[0] !== 32'h8C220004) begin nFails++; $display("[TB] FAIL ifetch_iload: got %h want 8c220004", iload[0]); end
    tick();
    clearInputs();
    nChecks++; if ({ramREN, iwait} !== 3'b011) begin nFails++; $display("[TB] FAIL ifetch_return_idle: got %b want 011", {ramREN, iwait}); end
  endtask

  task automatic test_d_over_i();
    iREN = 2'b01; iaddr[0] = 32'h80;
    dWEN = 2'b10; daddr[1] = 32'h100; dstore[1] = 32'hDEAD; ramstate = RS_BUSY;
    tick();
    nChecks++; if ({ramREN, ramWEN} !== 2'b01) begin nFails++; $display("[TB] FAIL dwr_strobe: got %b want 01", {ramREN, ramWEN}); end
    nChecks++; if (ramaddr !== 32'h100 || ramstore !== 32'hDEAD) begin nFails++; $display("[TB] FAIL dwr_bus: got %h/%h want 100/dead", ramaddr, ramstore); end
    nChecks++; if (iwait !== 2'b11) begin nFails++; $display("[TB] FAIL dwr_iwait_high: got %b want 11", iwait); end
    ramstate = RS_ACCESS;
    #1;
    nChecks++; if (dwait !== 2'b01 || iwait !== 2'b11) begin nFails++; $display("[TB] FAIL dwr_done: got d %b i %b want 01 11", dwait, iwait); end
    tick();
    dWEN = 2'b00; ramstate = RS_BUSY;
    #1;
    nChecks++; if ({ramREN, ramWEN} !== 2'b00) begin nFails++; $display("[TB] FAIL gap_idle: got %b want 00", {ramREN, ramWEN}); end
    tick();
    nChecks++; if (ramREN !== 1'b1 || ramaddr !== 32'h80) begin nFails++; $display("[TB] FAIL ird_after_dwr: got %b %h want 1 80", ramREN, ramaddr); end
    ramstate = RS_ACCESS; ramload = 32'h1111;
    #1;
    nChecks++; if (iwait !== 2'b10 || iload[0] !== 32'h1111) begin nFails++; $display("[TB] FAIL ird_after_dwr_done: got %b %h want 10 1111", iwait, iload[0]); end
    tick();
    clearInputs();
  endtask

  task automatic test_round_robin();
    logic [31:0] expAddr;
    logic [1:0]  expWait;
    nRST = 1'b0;
    #1;
    tick();
    nRST = 1'b1;
    dREN = 2'b11; daddr[0] = 32'h10; daddr[1] = 32'h20; ramstate = RS_BUSY;
    for (int k = 0; k < 4; k++) begin
      expAddr = (k % 2 == 0) ? 32'h10 : 32'h20;
      expWait = (k % 2 == 0) ? 2'b10 : 2'b01;
      tick();
      nChecks++; if (ramREN !== 1'b1 || ramaddr !== expAddr) begin nFails++; $display("[TB] FAIL rr_grant_%0d: got %b %h want 1 %h", k, ramREN, ramaddr, expAddr); end
      ramstate = RS_ACCESS;
      #1;
      nChecks++; if (dwait !== expWait) begin nFails++; $display("[TB] FAIL rr_dwait_%0d: got %b want %b", k, dwait, expWait); end
      tick();
      ramstate = RS_BUSY;
    end
    clearInputs();
  endtask

  task automatic test_snoop_miss();
    dREN = 2'b01; cctrans = 2'b01; ccwrite = 2'b01; daddr[0] = 32'h200; ramstate = RS_BUSY;
    tick();
    nChecks++; if (ccwait !== 2'b10 || ccinv !== 2'b10) begin nFails++; $display("[TB] FAIL snoop_cc: got wait %b inv %b want 10 10", ccwait, ccinv); end
    nChecks++; if (ccsnoopaddr[1] !== 32'h200) begin nFails++; $display("[TB] FAIL snoop_addr: got %h want 200", ccsnoopaddr[1]); end
    nChecks++; if ({ramREN, ramWEN} !== 2'b00) begin nFails++; $display("[TB] FAIL snoop_no_ram: got %b want 00", {ramREN, ramWEN}); end
    tick();
    nChecks++; if (ccwait !== 2'b00 || ramREN !== 1'b1 || ramaddr !== 32'h200) begin nFails++; $display("[TB] FAIL snoop_miss_drd: got %b %b %h want 00 1 200", ccwait, ramREN, ramaddr); end
    ramstate = RS_ACCESS; ramload = 32'h1234;
    #1;
    nChecks++; if (dwait !== 2'b10 || dload[0] !== 32'h1234) begin nFails++; $display("[TB] FAIL snoop_miss_done: got %b %h want 10 1234", dwait, dload[0]); end
    tick();
    clearInputs();
  endtask

  task automatic enterFwd();
    dREN = 2'b01; cctrans = 2'b11; ccwrite = 2'b01; daddr[0] = 32'h200; ramstate = RS_BUSY;
    tick();
    nChecks++; if (ccwait !== 2'b10) begin nFails++; $display("[TB] FAIL fwd_snoop_wait: got %b want 10", ccwait); end
    tick();
  endtask

  task automatic test_snoop_fwd();
    enterFwd();
    nChecks++; if ({ramREN, ramWEN} !== 2'b00 || ccwait !== 2'b10) begin nFails++; $display("[TB] FAIL fwd_hold: got ram %b wait %b want 00 10", {ramREN, ramWEN}, ccwait); end
    tick();
    dWEN = 2'b10; daddr[1] = 32'h200; dstore[1] = 32'hBEEF;
    #1;
    nChecks++; if ({ramREN, ramWEN} !== 2'b01 || ramaddr !== 32'h200 || ramstore !== 32'hBEEF) begin nFails++; $display("[TB] FAIL fwd_write: got %b %h %h want 01 200 beef", {ramREN, ramWEN}, ramaddr, ramstore); end
    nChecks++; if (dload[0] !== 32'hBEEF || dwait !== 2'b11) begin nFails++; $display("[TB] FAIL fwd_dload: got %h %b want beef 11", dload[0], dwait); end
    ramstate = RS_ACCESS;
    #1;
    nChecks++; if (dwait !== 2'b00 || ccwait !== 2'b10) begin nFails++; $display("[TB] FAIL fwd_done: got %b %b want 00 10", dwait, ccwait); end
    tick();
    clearInputs();
    nChecks++; if (ccwait !== 2'b00 || {ramREN, ramWEN} !== 2'b00) begin nFails++; $display("[TB] FAIL fwd_release: got %b %b want 00 00", ccwait, {ramREN, ramWEN}); end
  endtask

  task automatic test_reset_in_fwd();
    enterFwd();
    dWEN = 2'b10; daddr[1] = 32'h200; dstore[1] = 32'hBEEF;
    #1;
    nChecks++; if (ramWEN !== 1'b1) begin nFails++; $display("[TB] FAIL rstfwd_pre: got %b want 1", ramWEN); end
    nRST = 1'b0;
    #1;
    nChecks++; if (ramWEN !== 1'b0 || ccwait !== 2'b00) begin nFails++; $display("[TB] FAIL rstfwd_abort: got %b %b want 0 00", ramWEN, ccwait); end
    nChecks++; if (iwait !== 2'b11 || dwait !== 2'b11) begin nFails++; $display("[TB] FAIL rstfwd_waits: got %b %b want 11 11", iwait, dwait); end
    dWEN = 2'b00; cctrans = 2'b01;
    tick();
    nChecks++; if ({ramREN, ramWEN} !== 2'b00) begin nFails++; $display("[TB] FAIL rstfwd_no_strobe: got %b want 00", {ramREN, ramWEN}); end
    nRST = 1'b1;
    tick();
    nChecks++; if (ccwait !== 2'b10 || ccsnoopaddr[1] !== 32'h200) begin nFails++; $display("[TB] FAIL rstfwd_reserve: got %b %h want 10 200", ccwait, ccsnoopaddr[1]); end
    tick();
    ramstate = RS_ACCESS; ramload = 32'h5555;
    #1;
    nChecks++; if (dwait !== 2'b10 || dload[0] !== 32'h5555) begin nFails++; $display("[TB] FAIL rstfwd_complete: got %b %h want 10 5555", dwait, dload[0]); end
    tick();
    clearInputs();
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_d_over_i();
    test_round_robin();
    test_snoop_miss();
    test_snoop_fwd();
    test_reset_in_fwd();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
